// File: rtl/led_blinker_pkg.sv
// Shared encodings and helpers for the multi-channel LED blinker.
// Mode, rate and per-channel state types plus the rate-to-half-period lookup.
package led_blinker_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_SOLID = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_BURST = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    RATE_100HZ = 2'b00,
    RATE_50HZ  = 2'b01,
    RATE_10HZ  = 2'b10,
    RATE_1HZ   = 2'b11
  } rate_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ON   = 2'b01,
    OFF  = 2'b10
  } state_e;

  typedef struct packed {
    logic  enable;
    mode_e mode;
    rate_e rate;
  } cfg_t;

  // Half-period length in prescaler ticks.
  function automatic logic [6:0] half_ticks(input rate_e rate);
    logic [6:0] half;
    half = 7'd1;
    case (rate)
      RATE_100HZ: half = 7'd1;
      RATE_50HZ:  half = 7'd2;
      RATE_10HZ:  half = 7'd10;
      RATE_1HZ:   half = 7'd100;
      default:    half = 7'd1;
    endcase
    return half;
  endfunction

endpackage

// File: rtl/led_blink_channel.sv
// One LED channel: IDLE/ON/OFF state machine with phase and burst counters.
// Any change of {enable, mode, rate} restarts the channel from scratch.
module led_blink_channel
  import led_blinker_pkg::*;
#(
  parameter int BURST = 3
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_tick,
  input  logic       i_enable,
  input  logic [1:0] i_rate,
  input  logic [1:0] i_mode,
  input  logic       i_trigger,
  output logic       o_led_drive,
  output logic       o_busy
);

  localparam int BW = $clog2(BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(BURST);

  state_e        state_q, state_d;
  logic [6:0]    phase_q, phase_d;
  logic [BW-1:0] burst_q, burst_d;
  cfg_t          cfg_q, cfg_d;
  logic          busy_d, led_d;
  logic          restart, wrap;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    cfg_d   = '{enable: i_enable, mode: mode_e'(i_mode), rate: rate_e'(i_rate)};
    restart = (cfg_d != cfg_q);
    wrap    = (phase_q == half_ticks(cfg_d.rate) - 7'd1);
    state_d = state_q;
    phase_d = phase_q;
    burst_d = burst_q;
    busy_d  = o_busy;

    if (!cfg_d.enable || cfg_d.mode == MODE_OFF || cfg_d.mode == MODE_SOLID) begin
      state_d = IDLE;
      phase_d = '0;
      burst_d = '0;
      busy_d  = 1'b0;
    end else if (restart) begin
      // A restart swallows a coincident tick.
      phase_d = '0;
      burst_d = '0;
      busy_d  = 1'b0;
      if (cfg_d.mode == MODE_BLINK) begin
        state_d = ON;
      end else if (i_trigger) begin
        state_d = ON;
        busy_d  = 1'b1;
      end else begin
        state_d = IDLE;
      end
    end else if (cfg_d.mode == MODE_BLINK) begin
      if (i_tick) begin
        if (wrap) begin
          state_d = (state_q == ON) ? OFF : ON;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 7'd1;
        end
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_trigger) begin
            state_d = ON;
            busy_d  = 1'b1;
            burst_d = '0;
            phase_d = '0;
          end
        end
        ON: begin
          if (i_tick) begin
            if (wrap) begin
              state_d = OFF;
              burst_d = burst_q + BW'(1);
              phase_d = '0;
            end else begin
              phase_d = phase_q + 7'd1;
            end
          end
        end
        OFF: begin
          if (i_tick) begin
            if (wrap) begin
              phase_d = '0;
              if (burst_q < BURST_MAX) begin
                state_d = ON;
              end else begin
                state_d = IDLE;
                busy_d  = 1'b0;
              end
            end else begin
              phase_d = phase_q + 7'd1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end

    led_d = cfg_d.enable && (cfg_d.mode == MODE_SOLID || state_d == ON);
  end

  always_ff @(posedge i_clock) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (i_reset) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      burst_q     <= '0;
      cfg_q       <= '0;
      o_led_drive <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      burst_q     <= burst_d;
      cfg_q       <= cfg_d;
      o_led_drive <= led_d;
      o_busy      <= busy_d;
    end
  end

endmodule

// File: rtl/led_blinker_multi.sv
// Multi-channel LED blinker: one free-running tick prescaler shared by
// CHANNELS independent blink/burst channels, all outputs registered.
module led_blinker_multi
  import led_blinker_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CLK_HZ   = 25_000_000,
  parameter int TICK_HZ  = 200,
  parameter int BURST    = 3
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [CHANNELS-1:0]   i_enable,
  input  logic [2*CHANNELS-1:0] i_rate,
  input  logic [2*CHANNELS-1:0] i_mode,
  input  logic [CHANNELS-1:0]   i_trigger,
  output logic [CHANNELS-1:0]   o_led_drive,
  output logic [CHANNELS-1:0]   o_busy,
  output logic                  o_tick
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int CW       = $clog2(TICK_DIV);
  localparam logic [CW-1:0] COUNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  // o_tick is the registered terminal count, so it lands TICK_DIV edges after reset release.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      count  <= '0;
      o_tick <= 1'b0;
    end else begin
      o_tick <= (count == COUNT_LAST);
      count  <= (count == COUNT_LAST) ? '0 : count + CW'(1);
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    led_blink_channel #(
      .BURST(BURST)
    ) u_channel (
      .i_clock    (i_clock),
      .i_reset    (i_reset),
      .i_tick     (o_tick),
      .i_enable   (i_enable[c]),
      .i_rate     (i_rate[2*c+1:2*c]),
      .i_mode     (i_mode[2*c+1:2*c]),
      .i_trigger  (i_trigger[c]),
      .o_led_drive(o_led_drive[c]),
      .o_busy     (o_busy[c])
    );
  end

endmodule

// File: tb/tb_led_blinker_multi.sv
// Self-checking bench for led_blinker_multi: directed scenarios plus random
// stimulus, compared cycle by cycle against a tick-count arithmetic model.
module tb_led_blinker_multi;

  localparam int CH       = 4;
  localparam int TICK_DIV = 10;
  localparam int NBURST   = 3;

  logic          clk;
  logic          rst;
  logic [CH-1:0] enable;
  logic [2*CH-1:0] rate;
  logic [2*CH-1:0] mode;
  logic [CH-1:0] trigger;
  logic [CH-1:0] o_led_drive;
  logic [CH-1:0] o_busy;
  logic          o_tick;

  int checks = 0;
  int errors = 0;

  // Reference model: each active channel is described by the number of ticks
  // seen since entry; LED is on during even-numbered half-periods.
  int            m_n;
  logic          m_tick;
  int            m_t   [CH];
  bit            m_run [CH];
  logic [4:0]    m_prev[CH];
  logic [CH-1:0] m_led;
  logic [CH-1:0] m_busy;

  led_blinker_multi #(
    .CHANNELS(CH),
    .CLK_HZ  (2000),
    .TICK_HZ (200),
    .BURST   (NBURST)
  ) dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_enable   (enable),
    .i_rate     (rate),
    .i_mode     (mode),
    .i_trigger  (trigger),
    .o_led_drive(o_led_drive),
    .o_busy     (o_busy),
    .o_tick     (o_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int half_of(input logic [1:0] r);
    case (r)
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 10;
      default: return 100;
    endcase
  endfunction

  // Advance one clock edge, update the model from the inputs the DUT sampled,
  // and return 1 time unit after the edge.
  task automatic step();
    logic       tick_in;
    logic       en, tg;
    logic [1:0] md, rt;
    logic [4:0] cfg;
    int         h, halves;
    @(posedge clk);
    if (rst) begin
      m_n    = 0;
      m_tick = 1'b0;
      m_led  = '0;
      m_busy = '0;
      for (int c = 0; c < CH; c++) begin
        m_t[c]    = 0;
        m_run[c]  = 1'b0;
        m_prev[c] = '0;
      end
    end else begin
      tick_in = m_tick;
      m_n++;
      for (int c = 0; c < CH; c++) begin
        en  = enable[c];
        tg  = trigger[c];
        md  = mode[2*c +: 2];
        rt  = rate[2*c +: 2];
        cfg = {en, md, rt};
        h   = half_of(rt);
        if (cfg != m_prev[c]) begin
          m_t[c]   = 0;
          m_run[c] = en && (md == 2'd2 || (md == 2'd3 && tg));
        end else if (en && md == 2'd2) begin
          if (tick_in) m_t[c]++;
        end else if (en && md == 2'd3) begin
          if (!m_run[c]) begin
            if (tg) begin
              m_run[c] = 1'b1;
              m_t[c]   = 0;
            end
          end else if (tick_in) begin
            m_t[c]++;
            if (m_t[c] / h >= 2 * NBURST) m_run[c] = 1'b0;
          end
        end
        m_prev[c] = cfg;
        halves    = m_t[c] / h;
        m_led[c]  = en && (md == 2'd1 ||
                           (md == 2'd2 && halves % 2 == 0) ||
                           (md == 2'd3 && m_run[c] && halves % 2 == 0));
        m_busy[c] = en && md == 2'd3 && m_run[c];
      end
      m_tick = (m_n % TICK_DIV == 0);
    end
    #1;
  endtask

  task automatic test_reset();
    logic want_tick;
    rst = 1'b1; enable = '0; mode = '0; rate = '0; trigger = '0;
    repeat (3) begin
      step();
      checks++;
      if ({o_led_drive, o_busy, o_tick} !== 9'b0) begin
        errors++;
        $display("FAIL reset_hold: led=%b busy=%b tick=%b, expected all zero", o_led_drive, o_busy, o_tick);
      end
    end
    rst = 1'b0;
    for (int i = 1; i <= 35; i++) begin
      step();
      want_tick = (i % TICK_DIV == 0);
      checks++;
      if (o_tick !== want_tick || o_led_drive !== '0 || o_busy !== '0) begin
        errors++;
        $display("FAIL reset_release cyc %0d: tick=%b led=%b busy=%b, expected tick=%b led=0000 busy=0000",
                 i, o_tick, o_led_drive, o_busy, want_tick);
      end
    end
  endtask

  task automatic test_blink_ch0();
    enable[0] = 1'b1; mode[1:0] = 2'b10; rate[1:0] = 2'b00;
    step();
    checks++;
    if (o_led_drive !== 4'b0001) begin
      errors++;
      $display("FAIL blink_entry: led=%b, expected 0001", o_led_drive);
    end
    for (int i = 0; i < 80; i++) begin
      step();
      checks++;
      if (o_led_drive !== m_led || o_busy !== m_busy || o_tick !== m_tick) begin
        errors++;
        $display("FAIL blink_ch0 cyc %0d: led=%b busy=%b tick=%b, expected led=%b busy=%b tick=%b",
                 i, o_led_drive, o_busy, o_tick, m_led, m_busy, m_tick);
      end
    end
  endtask

  task automatic test_rate_switch();
    enable[1] = 1'b1; mode[3:2] = 2'b10; rate[3:2] = 2'b11;
    for (int i = 0; i < 1100; i++) begin
      step();
      checks++;
      if (o_led_drive !== m_led || o_busy !== m_busy || o_tick !== m_tick) begin
        errors++;
        $display("FAIL slow_blink cyc %0d: led=%b busy=%b tick=%b, expected led=%b busy=%b tick=%b",
                 i, o_led_drive, o_busy, o_tick, m_led, m_busy, m_tick);
      end
    end
    // 1100 cycles after entry the channel is inside its second (off) half.
    checks++;
    if (o_led_drive[1] !== 1'b0) begin
      errors++;
      $display("FAIL slow_blink_off: led1=%b, expected 0", o_led_drive[1]);
    end
    rate[3:2] = 2'b00;
    step();
    checks++;
    if (o_led_drive[1] !== 1'b1) begin
      errors++;
      $display("FAIL rate_switch_entry: led1=%b, expected 1", o_led_drive[1]);
    end
    for (int i = 0; i < 60; i++) begin
      step();
      checks++;
      if (o_led_drive !== m_led || o_busy !== m_busy || o_tick !== m_tick) begin
        errors++;
        $display("FAIL rate_switch cyc %0d: led=%b busy=%b tick=%b, expected led=%b busy=%b tick=%b",
                 i, o_led_drive, o_busy, o_tick, m_led, m_busy, m_tick);
      end
    end
  endtask

  task automatic test_burst();
    int   pulses, busy_cycles;
    logic prev;
    enable[2] = 1'b1; mode[5:4] = 2'b11; rate[5:4] = 2'b00;
    repeat (3) step();
    checks++;
    if (o_led_drive[2] !== 1'b0 || o_busy[2] !== 1'b0) begin
      errors++;
      $display("FAIL burst_armed: led2=%b busy2=%b, expected 0 0", o_led_drive[2], o_busy[2]);
    end
    pulses = 0; busy_cycles = 0; prev = 1'b0;
    for (int i = 0; i < 80; i++) begin
      trigger[2] = (i == 0 || i == 25);
      step();
      if (o_led_drive[2] && !prev) pulses++;
      prev = o_led_drive[2];
      if (o_busy[2]) busy_cycles++;
      checks++;
      if (o_led_drive !== m_led || o_busy !== m_busy || o_tick !== m_tick) begin
        errors++;
        $display("FAIL burst cyc %0d: led=%b busy=%b tick=%b, expected led=%b busy=%b tick=%b",
                 i, o_led_drive, o_busy, o_tick, m_led, m_busy, m_tick);
      end
    end
    trigger[2] = 1'b0;
    checks++;
    if (pulses != NBURST) begin
      errors++;
      $display("FAIL burst_pulses: got %0d, expected %0d", pulses, NBURST);
    end
    checks++;
    if (busy_cycles < 51 || busy_cycles > 60) begin
      errors++;
      $display("FAIL burst_busy_len: got %0d cycles, expected 51..60", busy_cycles);
    end
  endtask

  task automatic test_enable_drop();
    enable[3] = 1'b1; mode[7:6] = 2'b10; rate[7:6] = 2'b01;
    repeat (5) step();
    checks++;
    if (o_led_drive[3] !== 1'b1) begin
      errors++;
      $display("FAIL ch3_on: led3=%b, expected 1", o_led_drive[3]);
    end
    enable[3] = 1'b0;
    step();
    checks++;
    if (o_led_drive[3] !== 1'b0) begin
      errors++;
      $display("FAIL ch3_disable: led3=%b, expected 0", o_led_drive[3]);
    end
    repeat (7) step();
    enable[3] = 1'b1;
    step();
    checks++;
    if (o_led_drive[3] !== 1'b1) begin
      errors++;
      $display("FAIL ch3_reenable: led3=%b, expected 1", o_led_drive[3]);
    end
    for (int i = 0; i < 50; i++) begin
      step();
      checks++;
      if (o_led_drive !== m_led || o_busy !== m_busy || o_tick !== m_tick) begin
        errors++;
        $display("FAIL ch3_restart cyc %0d: led=%b busy=%b tick=%b, expected led=%b busy=%b tick=%b",
                 i, o_led_drive, o_busy, o_tick, m_led, m_busy, m_tick);
      end
    end
    mode[7:6] = 2'b01;
    for (int i = 0; i < 30; i++) begin
      step();
      checks++;
      if (o_led_drive[3] !== 1'b1 || o_busy[3] !== 1'b0) begin
        errors++;
        $display("FAIL ch3_solid cyc %0d: led3=%b busy3=%b, expected 1 0", i, o_led_drive[3], o_busy[3]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    trigger[2] = 1'b1;
    step();
    trigger[2] = 1'b0;
    repeat (15) step();
    checks++;
    if (o_busy[2] !== 1'b1) begin
      errors++;
      $display("FAIL burst_before_reset: busy2=%b, expected 1", o_busy[2]);
    end
    rst = 1'b1;
    step();
    checks++;
    if (o_led_drive[2] !== 1'b0 || o_busy[2] !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_burst: led2=%b busy2=%b, expected 0 0", o_led_drive[2], o_busy[2]);
    end
    rst = 1'b0;
    for (int i = 0; i < 80; i++) begin
      step();
      checks++;
      if (o_led_drive[2] !== 1'b0 || o_busy[2] !== 1'b0 ||
          o_led_drive !== m_led || o_busy !== m_busy || o_tick !== m_tick) begin
        errors++;
        $display("FAIL post_reset cyc %0d: led=%b busy=%b tick=%b, expected led=%b busy=%b tick=%b",
                 i, o_led_drive, o_busy, o_tick, m_led, m_busy, m_tick);
      end
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 19) == 0) begin
        int c;
        c = $urandom_range(0, CH - 1);
        enable[c]      = ($urandom_range(0, 7) != 0);
        mode[2*c +: 2] = 2'($urandom_range(0, 3));
        rate[2*c +: 2] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3))
                                                      : 2'($urandom_range(0, 1));
      end
      trigger = 4'($urandom) & 4'($urandom) & 4'($urandom);
      step();
      checks++;
      if (o_led_drive !== m_led || o_busy !== m_busy || o_tick !== m_tick) begin
        errors++;
        $display("FAIL random cyc %0d: led=%b busy=%b tick=%b, expected led=%b busy=%b tick=%b",
                 cyc, o_led_drive, o_busy, o_tick, m_led, m_busy, m_tick);
      end
    end
    trigger = '0;
  endtask

  initial begin
    rst = 1'b1; enable = '0; mode = '0; rate = '0; trigger = '0;
    m_n = 0; m_tick = 1'b0; m_led = '0; m_busy = '0;
    for (int c = 0; c < CH; c++) begin
      m_t[c] = 0; m_run[c] = 1'b0; m_prev[c] = '0;
    end
    test_reset();
    test_blink_ch0();
    test_rate_switch();
    test_burst();
    test_enable_drop();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
